// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: round-robin dispatcher in front of a 1-to-4 demux.
// A single valid/ready input stream is bound one word at a time to the next
// enabled lane. The word is held on out_data/out_valid until that lane is ready.
// Back-to-back delivery sustains one word per cycle.
`timescale 1ns/1ps

module demux_dispatch_ctrl #(
    parameter int DATA_W    = 10,
    parameter int CNT_W     = 16,
    parameter bit ZERO_IDLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        en_mask,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_valid,
    input  logic [3:0]        lane_ready,
    output logic [1:0]        sel,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  data_q;
    logic [3:0]         valid_q;
    logic [1:0]         sel_q;
    logic [1:0]         last_lane_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               accept;
    logic               xfer;
    logic [1:0]         base;
    logic [1:0]         sel_d;

    // First enabled lane scanning base+1, base+2, base+3, base (mod 4).
    // An all-zero mask returns base, but in_ready is low then so it is never used.
    function automatic logic [1:0] rr_pick(input logic [1:0] b, input logic [3:0] mask);
        logic [1:0] cand;
        logic       found;
        rr_pick = b;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = b + 2'(k);
            if (!found && mask[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    // Handshake decode and round-robin pick for the word being accepted this cycle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        in_ready = 1'b0;
        xfer     = 1'b0;
        base     = last_lane_q;
        if (state_q == IDLE) begin
            in_ready = |en_mask;
        end else begin
            // The held word completes on its bound lane; other lanes' ready is ignored.
            xfer     = lane_ready[sel_q];
            in_ready = lane_ready[sel_q] & (|en_mask);
            base     = sel_q;
        end
        accept = in_valid & in_ready;
        sel_d  = rr_pick(base, en_mask);
    end

    // Dispatcher FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // A word held at reset is dropped; last_lane=3 makes the first pick lane 0 upward.
            state_q     <= IDLE;
            data_q      <= '0;
            valid_q     <= 4'b0000;
            sel_q       <= 2'd0;
            last_lane_q <= 2'd3;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= in_data;
                        sel_q   <= sel_d;
                        valid_q <= 4'b0001 << sel_d;
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        last_lane_q <= sel_q;
                        cnt_q       <= cnt_q + 1'b1;
                        if (accept) begin
                            // Back-to-back: reload immediately, stay in SEND.
                            data_q  <= in_data;
                            sel_q   <= sel_d;
                            valid_q <= 4'b0001 << sel_d;
                        end else begin
                            valid_q <= 4'b0000;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                            if (ZERO_IDLE) begin
                                data_q <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sel       = sel_q;
    assign busy      = busy_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// tb_demux_dispatch_ctrl: directed bench for the round-robin demux dispatcher.
// Runs with CNT_W=4 so the counter wrap is reachable in a short run.
`timescale 1ns/1ps

module tb_demux_dispatch_ctrl;

    localparam int DATA_W = 10;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic [3:0]        en_mask;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_valid;
    logic [3:0]        lane_ready;
    logic [1:0]        sel;
    logic              busy;
    logic [CNT_W-1:0]  word_cnt;

    int tests_run;
    int tests_failed;

    demux_dispatch_ctrl #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .ZERO_IDLE(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_mask   (en_mask),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .lane_ready(lane_ready),
        .sel       (sel),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compare every registered output at once.
    task automatic check_state(input string tag, input logic [3:0] ov, input logic [DATA_W-1:0] d,
                               input logic [1:0] s, input logic b, input int cnt);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".out_data"},  32'(out_data),  32'(d));
        check({tag, ".sel"},       32'(sel),       32'(s));
        check({tag, ".busy"},      32'(busy),      32'(b));
        check({tag, ".word_cnt"},  32'(word_cnt),  32'(cnt % 16));
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Stream n consecutive words base_word, base_word+1, ... with no gaps.
    // lane_seq holds the expected lane for word i at bits [2*(i%4) +: 2].
    task automatic run_burst(input string tag, input int n, input logic [DATA_W-1:0] base_word,
                             input logic [7:0] lane_seq, input int cnt0);
        logic [1:0] lane;
        edge_step();
        in_valid = 1'b1;
        in_data  = base_word;
        mid();
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < n; i++) begin
            edge_step();
            if (i < n - 1) in_data = base_word + DATA_W'(i + 1);
            else           in_valid = 1'b0;
            mid();
            lane = lane_seq[2*(i%4) +: 2];
            check_state($sformatf("%s.w%0d", tag, i), 4'b0001 << lane,
                        base_word + DATA_W'(i), lane, 1'b1, cnt0 + i);
        end
        edge_step();
        mid();
        check_state({tag, ".end"}, 4'b0000, '0, lane, 1'b0, cnt0 + n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        en_mask    = 4'b0000;
        in_data    = '0;
        in_valid   = 1'b0;
        lane_ready = 4'b0000;

        // Reset state.
        mid();
        check_state("reset", 4'b0000, '0, 2'd0, 1'b0, 0);
        check("reset.in_ready", 32'(in_ready), 32'd0);
        edge_step();
        rst = 1'b0;

        // 1: all lanes, back-to-back -> lanes 0,1,2,3, word_cnt ends at 4.
        en_mask    = 4'b1111;
        lane_ready = 4'b1111;
        run_burst("t1", 4, 10'h001, {2'd3, 2'd2, 2'd1, 2'd0}, 0);

        // 2: mask 0101 -> lanes 0,2,0,2 only.
        en_mask = 4'b0101;
        run_burst("t2", 4, 10'h011, {2'd2, 2'd0, 2'd2, 2'd0}, 4);

        // 3: 0x155 bound to lane1 and stalled; other lanes' ready must be ignored.
        edge_step();
        en_mask    = 4'b0010;
        lane_ready = 4'b1101;
        in_valid   = 1'b1;
        in_data    = 10'h155;
        mid();
        check("t3.accept_ready", 32'(in_ready), 32'd1);
        edge_step();
        en_mask = 4'b1111;
        in_data = 10'h0F0;
        for (int i = 0; i < 5; i++) begin
            mid();
            check_state($sformatf("t3.stall%0d", i), 4'b0010, 10'h155, 2'd1, 1'b1, 8);
            check($sformatf("t3.stall%0d.in_ready", i), 32'(in_ready), 32'd0);
            edge_step();
        end
        lane_ready = 4'b1111;
        mid();
        check("t3.release_ready", 32'(in_ready), 32'd1);
        edge_step();
        in_valid = 1'b0;
        mid();
        check_state("t3.next", 4'b0100, 10'h0F0, 2'd2, 1'b1, 9);
        edge_step();
        mid();
        check_state("t3.end", 4'b0000, '0, 2'd2, 1'b0, 10);

        // 4: empty mask blocks acceptance; enabling lane0 lets the word through.
        edge_step();
        en_mask  = 4'b0000;
        in_valid = 1'b1;
        in_data  = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("t4.blocked%0d.in_ready", i), 32'(in_ready), 32'd0);
            check_state($sformatf("t4.blocked%0d", i), 4'b0000, '0, 2'd2, 1'b0, 10);
            edge_step();
        end
        en_mask = 4'b0001;
        mid();
        check("t4.enable_ready", 32'(in_ready), 32'd1);
        edge_step();
        in_valid = 1'b0;
        mid();
        check_state("t4.lane0", 4'b0001, 10'h2A5, 2'd0, 1'b1, 10);
        edge_step();
        mid();
        check_state("t4.end", 4'b0000, '0, 2'd0, 1'b0, 11);

        // 5: asynchronous reset while holding a word on lane2.
        edge_step();
        en_mask    = 4'b0100;
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        in_data    = 10'h3C3;
        edge_step();
        in_valid = 1'b0;
        mid();
        check_state("t5.held", 4'b0100, 10'h3C3, 2'd2, 1'b1, 11);
        edge_step();
        #2;
        rst = 1'b1;
        #1;
        check_state("t5.async_rst", 4'b0000, '0, 2'd0, 1'b0, 0);
        edge_step();
        rst = 1'b0;

        // 6a: 17 transfers from reset; first goes to lane0, counter wraps to 0 then 1.
        en_mask    = 4'b1111;
        lane_ready = 4'b1111;
        run_burst("t6", 17, 10'h100, {2'd3, 2'd2, 2'd1, 2'd0}, 0);

        // 6b: mask 1111 -> 1000 while lane1 holds a word.
        edge_step();
        lane_ready = 4'b0000;
        in_valid   = 1'b1;
        in_data    = 10'h0B1;
        mid();
        check("t6m.accept_ready", 32'(in_ready), 32'd1);
        edge_step();
        en_mask = 4'b1000;
        in_data = 10'h0B2;
        mid();
        check_state("t6m.held0", 4'b0010, 10'h0B1, 2'd1, 1'b1, 1);
        check("t6m.stall_ready", 32'(in_ready), 32'd0);
        edge_step();
        mid();
        check_state("t6m.held1", 4'b0010, 10'h0B1, 2'd1, 1'b1, 1);
        lane_ready = 4'b1111;
        edge_step();
        in_valid = 1'b0;
        mid();
        check_state("t6m.lane3", 4'b1000, 10'h0B2, 2'd3, 1'b1, 2);
        edge_step();
        mid();
        check_state("t6m.end", 4'b0000, '0, 2'd3, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
